// File: rtl/fetch_ctrl.sv
// Fetch-stage controller: picks the redirect source, drives the PC mux and enables, and tracks I-cache miss timeouts.
// Optional macro FETCH_STALL_CNT_EN adds a saturating stall-cycle counter output (stall_cnt).
module fetch_ctrl #(
    parameter int unsigned MISS_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       jmp_IF,
    input  logic       br_taken_EX,
    input  logic       ret_M,
    input  logic       load_use,
    input  logic       cache_Ready,
    output logic       j_cntrl,
    output logic       E,
    output logic       F,
    output logic       pc_en,
    output logic       pc_hazard,
    output logic       flush_IF,
    output logic       flush_ID,
    output logic [1:0] state,
    output logic       timeout_err
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [9:0] stall_cnt
`endif
);

    localparam int unsigned CNT_W   = 8;
    localparam int unsigned STATE_W = 2;
    localparam logic [CNT_W-1:0] MISS_LAST = CNT_W'(MISS_TIMEOUT - 1);

    typedef enum logic [STATE_W-1:0] {
        RUN  = 2'b00,
        MISS = 2'b01,
        HAZ  = 2'b10,
        ERR  = 2'b11
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;
    logic               timeout_err_q, timeout_err_d;

    logic exm_redir;
    logic redir_m, redir_ex, redir_if;
    logic pc_en_c, pc_hazard_c;

    assign exm_redir = ret_M | br_taken_EX;

    // Next-state, miss counter and unregistered PC-control decode.
    always_comb begin
        state_d       = state_q;
        miss_cnt_d    = miss_cnt_q;
        timeout_err_d = timeout_err_q;
        redir_m       = 1'b0;
        redir_ex      = 1'b0;
        redir_if      = 1'b0;
        pc_en_c       = 1'b0;
        pc_hazard_c   = 1'b0;

        unique case (state_q)
            RUN: begin
                redir_m  = ret_M;
                redir_ex = ~ret_M & br_taken_EX;
                redir_if = ~exm_redir & jmp_IF & cache_Ready;
                pc_en_c  = (cache_Ready & ~load_use) | exm_redir;
                if (exm_redir) begin
                    state_d = RUN;
                end else if (!cache_Ready) begin
                    state_d    = MISS;
                    miss_cnt_d = '0;
                end else if (load_use) begin
                    state_d = HAZ;
                end
            end
            MISS: begin
                redir_m     = ret_M;
                redir_ex    = ~ret_M & br_taken_EX;
                pc_en_c     = exm_redir;
                pc_hazard_c = ~exm_redir;
                if (cache_Ready) begin
                    miss_cnt_d = '0;
                    if (!exm_redir) begin
                        state_d = RUN;
                    end
                end else begin
                    // Saturate rather than wrap if redirects hold us past the limit.
                    if (miss_cnt_q != '1) begin
                        miss_cnt_d = miss_cnt_q + CNT_W'(1);
                    end
                    if (!exm_redir && (miss_cnt_q >= MISS_LAST)) begin
                        state_d       = ERR;
                        timeout_err_d = 1'b1;
                    end
                end
            end
            HAZ: begin
                redir_m  = ret_M;
                redir_ex = ~ret_M & br_taken_EX;
                pc_en_c  = exm_redir;
                if (exm_redir || !load_use) begin
                    state_d = RUN;
                end
            end
            ERR: begin
                timeout_err_d = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= RUN;
            miss_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            miss_cnt_q    <= miss_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Zero-latency outputs, all held low while reset is asserted.
    assign j_cntrl     = reset & (redir_m | redir_ex | redir_if);
    assign E           = reset & redir_ex;
    assign F           = reset & redir_m;
    assign pc_en       = reset & pc_en_c;
    assign pc_hazard   = reset & pc_hazard_c;
    assign flush_IF    = reset & (redir_m | redir_ex | redir_if);
    assign flush_ID    = reset & (redir_m | redir_ex);
    assign state       = state_q;
    assign timeout_err = timeout_err_q;

`ifdef FETCH_STALL_CNT_EN
    localparam int unsigned STALL_W = 10;

    logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pc_en_c && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + STALL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl (built with MISS_TIMEOUT=4).
module tb_fetch_ctrl;

    logic       clk;
    logic       reset;
    logic       jmp_IF, br_taken_EX, ret_M, load_use, cache_Ready;
    logic       j_cntrl, E, F, pc_en, pc_hazard, flush_IF, flush_ID;
    logic [1:0] state;
    logic       timeout_err;
`ifdef FETCH_STALL_CNT_EN
    logic [9:0] stall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    fetch_ctrl #(.MISS_TIMEOUT(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .jmp_IF      (jmp_IF),
        .br_taken_EX (br_taken_EX),
        .ret_M       (ret_M),
        .load_use    (load_use),
        .cache_Ready (cache_Ready),
        .j_cntrl     (j_cntrl),
        .E           (E),
        .F           (F),
        .pc_en       (pc_en),
        .pc_hazard   (pc_hazard),
        .flush_IF    (flush_IF),
        .flush_ID    (flush_ID),
        .state       (state),
        .timeout_err (timeout_err)
`ifdef FETCH_STALL_CNT_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    // {j_cntrl, E, F, pc_en, pc_hazard, flush_IF, flush_ID}
    logic [6:0] outs;
    assign outs = {j_cntrl, E, F, pc_en, pc_hazard, flush_IF, flush_ID};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [6:0] exp_outs, input logic [1:0] exp_st,
                           input logic exp_err);
        chk({tag, "/outs"}, 32'(outs), 32'(exp_outs));
        chk({tag, "/state"}, 32'(state), 32'(exp_st));
        chk({tag, "/terr"}, 32'(timeout_err), 32'(exp_err));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic b, input logic j, input logic lu, input logic cr);
        ret_M = r; br_taken_EX = b; jmp_IF = j; load_use = lu; cache_Ready = cr;
        #1;
    endtask

    initial begin
        reset = 1'b0;
        drive(1, 1, 1, 1, 1);
        chk_all("reset_hold", 7'b0000000, 2'b00, 1'b0);
`ifdef FETCH_STALL_CNT_EN
        chk("stall_in_reset", 32'(stall_cnt), 32'd0);
`endif
        step();
        reset = 1'b1;

        // Free-running fetch
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 1);
            chk_all($sformatf("run_%0d", i), 7'b0001000, 2'b00, 1'b0);
            step();
        end

        // Redirect priority
        drive(1, 1, 1, 0, 1);
        chk_all("prio_m", 7'b1011011, 2'b00, 1'b0);
        step();
        drive(0, 1, 1, 0, 1);
        chk_all("prio_ex", 7'b1101011, 2'b00, 1'b0);
        step();
        drive(0, 0, 1, 0, 1);
        chk_all("prio_if", 7'b1001010, 2'b00, 1'b0);
        step();

        // jmp_IF with a miss is ignored; three miss cycles then ready
        drive(0, 0, 1, 0, 0);
        chk_all("jmp_on_miss", 7'b0000000, 2'b00, 1'b0);
        step();
        drive(0, 0, 0, 0, 0);
        chk_all("miss_1", 7'b0000100, 2'b01, 1'b0);
        step();
        chk_all("miss_2", 7'b0000100, 2'b01, 1'b0);
        step();
        drive(0, 0, 0, 0, 1);
        chk_all("miss_3", 7'b0000100, 2'b01, 1'b0);
        step();
        chk_all("miss_exit", 7'b0001000, 2'b00, 1'b0);

        // EX redirect while in MISS stays in MISS
        drive(0, 0, 0, 0, 0);
        step();
        drive(0, 1, 0, 0, 0);
        chk_all("miss_br", 7'b1101011, 2'b01, 1'b0);
        step();
        drive(0, 0, 0, 0, 1);
        chk_all("miss_br_after", 7'b0000100, 2'b01, 1'b0);
        step();
        chk_all("miss_br_exit", 7'b0001000, 2'b00, 1'b0);

        // Load-use hazard, resolved by an EX branch
        drive(0, 0, 0, 1, 1);
        chk_all("lu_run", 7'b0000000, 2'b00, 1'b0);
        step();
        drive(0, 0, 1, 1, 1);
        chk_all("haz_jmp_ignored", 7'b0000000, 2'b10, 1'b0);
        step();
        drive(0, 1, 0, 1, 1);
        chk_all("haz_br", 7'b1101011, 2'b10, 1'b0);
        step();
        drive(0, 0, 0, 0, 1);
        chk_all("haz_br_exit", 7'b0001000, 2'b00, 1'b0);

        // Hazard cleared by load_use dropping
        drive(0, 0, 0, 1, 1);
        step();
        drive(0, 0, 0, 0, 1);
        chk_all("haz_plain", 7'b0000000, 2'b10, 1'b0);
        step();
        chk_all("haz_plain_exit", 7'b0001000, 2'b00, 1'b0);

        // Miss timeout after 4 MISS cycles
        drive(0, 0, 0, 0, 0);
        step();
        for (int i = 0; i < 4; i++) begin
            chk_all($sformatf("to_miss_%0d", i), 7'b0000100, 2'b01, 1'b0);
            step();
        end
        chk_all("to_err", 7'b0000000, 2'b11, 1'b1);
        drive(1, 1, 1, 0, 1);
        chk_all("err_ret", 7'b0000000, 2'b11, 1'b1);
        step();
        step();
        chk_all("err_sticky", 7'b0000000, 2'b11, 1'b1);

        // Asynchronous reset out of ERR
        #2;
        reset = 1'b0;
        #1;
        chk_all("async_rst_err", 7'b0000000, 2'b00, 1'b0);
        step();
        reset = 1'b1;
        drive(0, 0, 0, 0, 1);
        chk_all("post_rst_run", 7'b0001000, 2'b00, 1'b0);

        // Asynchronous reset mid-MISS
        drive(0, 0, 0, 0, 0);
        step();
        step();
        chk("mid_miss_state", 32'(state), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk_all("async_rst_miss", 7'b0000000, 2'b00, 1'b0);
        step();
        reset = 1'b1;
        drive(0, 0, 0, 0, 1);
        chk_all("post_rst_miss", 7'b0001000, 2'b00, 1'b0);
        step();
        chk_all("post_rst_miss_2", 7'b0001000, 2'b00, 1'b0);

`ifdef FETCH_STALL_CNT_EN
        // Stall counter: 5 stalls, then saturation
        reset = 1'b0;
        drive(0, 0, 0, 0, 0);
        chk("stall_rst", 32'(stall_cnt), 32'd0);
        step();
        reset = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("stall_5", 32'(stall_cnt), 32'd5);
        for (int i = 0; i < 1100; i++) step();
        chk("stall_sat", 32'(stall_cnt), 32'd1023);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
